// File: rtl/nvdla_qch_pkg.sv
// Shared Q-channel definitions: sequencer state encoding, signal polarities, index sizing.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package nvdla_qch_pkg;

    typedef enum logic [2:0] {
        QCH_STOPPED = 3'd0,
        QCH_UP      = 3'd1,
        QCH_RUN     = 3'd2,
        QCH_DOWN    = 3'd3,
        QCH_UNWIND  = 3'd4,
        QCH_DENIED  = 3'd5
    } qch_state_e;

    // Q-channel signals are active-low: a low qreqn requests quiescence,
    // a low qacceptn acknowledges that the unit has stopped.
    localparam logic QREQN_STOP       = 1'b0;
    localparam logic QREQN_RUN        = 1'b1;
    localparam logic QACCEPTN_STOPPED = 1'b0;
    localparam logic QACCEPTN_RUN     = 1'b1;

    // Width of an index selecting one of n units (never narrower than 1 bit).
    function automatic int qch_idx_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/nvdla_qch_tmo_cnt.sv
// Accept-timeout counter for a Q-channel controller: counts enabled cycles, strobes when the count reaches tmo_cfg.
// Latency: tmo_expire is combinational from the count register; asserted during the tmo_cfg-th enabled cycle after a clear.
// Backpressure: none; tmo_cfg of zero disables the strobe, the counter simply wraps.
//
// Ports: nvdla_core_clk/nvdla_core_rstn clock and async active-low reset; tmo_clr restarts the count;
//        tmo_en counts this cycle; tmo_cfg threshold (sampled every cycle); tmo_expire strobe.
module nvdla_qch_tmo_cnt #(
    parameter int TMO_W = 8
) (
    input  logic             nvdla_core_clk,
    input  logic             nvdla_core_rstn,
    input  logic             tmo_clr,
    input  logic             tmo_en,
    input  logic [TMO_W-1:0] tmo_cfg,
    output logic             tmo_expire
);

    logic [TMO_W-1:0] tmo_cnt;
    logic [TMO_W:0]   cnt_nxt;

    // Compare against the count including the current cycle, so the strobe
    // lands exactly tmo_cfg cycles after the clear. One extra bit keeps the
    // increment from wrapping onto a small threshold.
    assign cnt_nxt    = {1'b0, tmo_cnt} + (TMO_W+1)'(1);
    assign tmo_expire = tmo_en && (tmo_cfg != '0) && (cnt_nxt == {1'b0, tmo_cfg});

    always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
        if (!nvdla_core_rstn) begin
            tmo_cnt <= '0;
        end else if (tmo_clr) begin
            tmo_cnt <= '0;
        end else if (tmo_en) begin
            tmo_cnt <= tmo_cnt + TMO_W'(1);
        end
    end

endmodule

// File: rtl/nvdla_qch_power_sequencer.sv
// Sequences one system Q-channel request across NUM_UNITS unit Q-channels: stop producer-first, wake consumer-first, unwind on deny/timeout.
// Latency: all outputs registered; each step costs one cycle plus the addressed unit's response time.
// Backpressure: waits indefinitely on the addressed unit unless tmo_cfg is non-zero during power-down; sys_qreqn is ignored mid-sequence.
//
// Ports: sys_qreqn/sys_qacceptn/sys_qdeny system Q-channel; unit_qreqn/unit_qacceptn/unit_qdeny per-unit Q-channels
//        (index 0 most upstream); tmo_cfg accept timeout (0 = off); seq_busy sequencing in progress;
//        deny_idx unit behind the last deny/timeout; tmo_pulse one-cycle timeout strobe.
module nvdla_qch_power_sequencer
    import nvdla_qch_pkg::*;
#(
    parameter int NUM_UNITS = 4,
    parameter int TMO_W     = 8
) (
    input  logic                                nvdla_core_clk,
    input  logic                                nvdla_core_rstn,
    input  logic                                sys_qreqn,
    output logic                                sys_qacceptn,
    output logic                                sys_qdeny,
    output logic [NUM_UNITS-1:0]                unit_qreqn,
    input  logic [NUM_UNITS-1:0]                unit_qacceptn,
    input  logic [NUM_UNITS-1:0]                unit_qdeny,
    input  logic [TMO_W-1:0]                    tmo_cfg,
    output logic                                seq_busy,
    output logic [qch_idx_w(NUM_UNITS)-1:0]     deny_idx,
    output logic                                tmo_pulse
);

    localparam int               IDX_W     = qch_idx_w(NUM_UNITS);
    localparam logic [IDX_W-1:0] IDX_FIRST = '0;
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(NUM_UNITS - 1);

    qch_state_e           state_q, state_d;
    logic [IDX_W-1:0]     idx_q, idx_d, idx_up, idx_dn;
    logic [NUM_UNITS-1:0] qreqn_d;
    logic                 acc_d, deny_d, busy_d, pulse_d;
    logic [IDX_W-1:0]     deny_idx_d;
    logic                 unit_awake, unit_stopped, unit_denied;
    logic                 tmr_clr, tmr_en, tmr_expire;

    assign idx_up = idx_q + IDX_W'(1);
    assign idx_dn = idx_q - IDX_W'(1);

    // Handshake status of the unit currently addressed by idx. A unit is
    // only considered running once it has withdrawn any pending deny.
    assign unit_awake   = (unit_qacceptn[idx_q] == QACCEPTN_RUN) && !unit_qdeny[idx_q];
    assign unit_stopped = (unit_qacceptn[idx_q] == QACCEPTN_STOPPED);
    assign unit_denied  = unit_qdeny[idx_q];

    // The timer only runs while waiting for a unit to stop.
    assign tmr_en = (state_q == QCH_DOWN);

    nvdla_qch_tmo_cnt #(
        .TMO_W (TMO_W)
    ) u_tmo_cnt (
        .nvdla_core_clk  (nvdla_core_clk),
        .nvdla_core_rstn (nvdla_core_rstn),
        .tmo_clr         (tmr_clr),
        .tmo_en          (tmr_en),
        .tmo_cfg         (tmo_cfg),
        .tmo_expire      (tmr_expire)
    );

    // Next-state and next-output logic. Outputs are computed from the
    // transition so that each registered output changes on the same edge
    // that samples the triggering input.
    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        qreqn_d    = unit_qreqn;
        acc_d      = sys_qacceptn;
        deny_d     = sys_qdeny;
        deny_idx_d = deny_idx;
        pulse_d    = 1'b0;
        tmr_clr    = 1'b0;

        case (state_q)
            QCH_STOPPED: begin
                if (sys_qreqn == QREQN_RUN) begin
                    state_d           = QCH_UP;
                    idx_d             = IDX_LAST;
                    qreqn_d[IDX_LAST] = QREQN_RUN;
                end
            end

            QCH_UP: begin
                if (unit_awake) begin
                    if (idx_q == IDX_FIRST) begin
                        state_d = QCH_RUN;
                        acc_d   = QACCEPTN_RUN;
                    end else begin
                        idx_d           = idx_dn;
                        qreqn_d[idx_dn] = QREQN_RUN;
                    end
                end
            end

            QCH_RUN: begin
                if (sys_qreqn == QREQN_STOP) begin
                    state_d            = QCH_DOWN;
                    idx_d              = IDX_FIRST;
                    qreqn_d[IDX_FIRST] = QREQN_STOP;
                    tmr_clr            = 1'b1;
                end
            end

            QCH_DOWN: begin
                // Deny beats a simultaneous accept; a unit that does accept
                // on the expiry cycle is treated as having made it in time.
                if (unit_denied || (!unit_stopped && tmr_expire)) begin
                    state_d        = QCH_UNWIND;
                    deny_idx_d     = idx_q;
                    qreqn_d[idx_q] = QREQN_RUN;
                    pulse_d        = !unit_denied;
                    tmr_clr        = 1'b1;
                end else if (unit_stopped) begin
                    tmr_clr = 1'b1;
                    if (idx_q == IDX_LAST) begin
                        state_d = QCH_STOPPED;
                        idx_d   = IDX_FIRST;
                        acc_d   = QACCEPTN_STOPPED;
                    end else begin
                        idx_d           = idx_up;
                        qreqn_d[idx_up] = QREQN_STOP;
                    end
                end
            end

            QCH_UNWIND: begin
                // Walk back towards the producer, waking one unit at a time.
                if (unit_awake) begin
                    if (idx_q == IDX_FIRST) begin
                        state_d = QCH_DENIED;
                        deny_d  = 1'b1;
                    end else begin
                        idx_d           = idx_dn;
                        qreqn_d[idx_dn] = QREQN_RUN;
                    end
                end
            end

            QCH_DENIED: begin
                if (sys_qreqn == QREQN_RUN) begin
                    state_d = QCH_RUN;
                    deny_d  = 1'b0;
                end
            end

            default: begin
                state_d = QCH_STOPPED;
                idx_d   = IDX_FIRST;
            end
        endcase

        busy_d = (state_d inside {QCH_UP, QCH_DOWN, QCH_UNWIND});
    end

    always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
        if (!nvdla_core_rstn) begin
            state_q      <= QCH_STOPPED;
            idx_q        <= '0;
            unit_qreqn   <= {NUM_UNITS{QREQN_STOP}};
            sys_qacceptn <= QACCEPTN_STOPPED;
            sys_qdeny    <= 1'b0;
            seq_busy     <= 1'b0;
            deny_idx     <= '0;
            tmo_pulse    <= 1'b0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            unit_qreqn   <= qreqn_d;
            sys_qacceptn <= acc_d;
            sys_qdeny    <= deny_d;
            seq_busy     <= busy_d;
            deny_idx     <= deny_idx_d;
            tmo_pulse    <= pulse_d;
        end
    end

endmodule
